// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the MASH 1-1-1 modulator.
package dsm_pkg;

  localparam int DSM_OUT_W   = 4;
  localparam int LFSR_W_DEF  = 15;
  localparam int LFSR_SD_DEF = 1;
  // Taps as offsets below the MSB: x^W + x^(W-1) + 1
  localparam int LFSR_TAP_A  = 1;
  localparam int LFSR_TAP_B  = 2;

  typedef enum logic [1:0] {
    ORD_DEF = 2'd0,
    ORD_1   = 2'd1,
    ORD_2   = 2'd2,
    ORD_3   = 2'd3
  } ord_e;

  function automatic logic [1:0] eff_order(
    input logic [1:0] o,
    input logic [1:0] max_o
  );
    logic [1:0] r;
    r = (o == ORD_DEF) ? ORD_1 : o;
    if (r > max_o) r = max_o;
    return r;
  endfunction

  function automatic logic [DSM_OUT_W-1:0] ext(
    input logic b
  );
    return {{(DSM_OUT_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/dsm_accum_stage.sv
// One wrap-around accumulator of the MASH chain.
// Sum and carry are combinational; acc updates on en.
module dsm_accum_stage
  import dsm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] add_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH:0]   raw;

  always_comb begin
    raw = {1'b0, acc_q}
        + {1'b0, add_i}
        + {{WIDTH{1'b0}}, cin_i};
    sum_o  = clr_i ? '0 : raw[WIDTH-1:0];
    cout_o = clr_i ? 1'b0 : raw[WIDTH];
    acc_d  = en_i ? sum_o : acc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/dsm_mash_mod.sv
// MASH 1-1-1 sigma-delta modulator with run-time order,
// LFSR dither and a double-buffered input word.
module dsm_mash_mod
  import dsm_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ORDER   = 3,
  parameter int LFSR_W  = LFSR_W_DEF,
  parameter int LFSR_SD = LFSR_SD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           ord,
  input  logic                 dither_en,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [DSM_OUT_W-1:0] dout,
  output logic                 dout_valid,
  output logic                 carry1
);

  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic                 full_q, full_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic                 c2d1_q, c2d1_d;
  logic                 c3d1_q, c3d1_d;
  logic                 c3d2_q, c3d2_d;
  logic [DSM_OUT_W-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 cy1_q, cy1_d;

  logic [1:0]           eo;
  logic                 clr2, clr3;
  logic                 dith, accept, fb;
  logic [WIDTH-1:0]     s1, s2, s3;
  logic                 c1, c2, c3;
  logic                 c2d1e, c3d1e, c3d2e;
  logic [DSM_OUT_W-1:0] y;

  assign eo   = eff_order(ord, 2'(ORDER));
  assign clr2 = (eo < 2'd2);
  assign clr3 = (eo < 2'd3);
  assign dith = dither_en & lfsr_q[0];

  dsm_accum_stage #(.WIDTH(WIDTH)) u_st1 (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en),
    .clr_i  (1'b0),
    .add_i  (x_q),
    .cin_i  (dith),
    .sum_o  (s1),
    .cout_o (c1)
  );

  if (ORDER >= 2) begin : g_st2
    dsm_accum_stage #(.WIDTH(WIDTH)) u_st2 (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en),
      .clr_i  (clr2),
      .add_i  (s1),
      .cin_i  (1'b0),
      .sum_o  (s2),
      .cout_o (c2)
    );
  end else begin : g_no2
    assign s2 = '0;
    assign c2 = 1'b0;
  end

  if (ORDER >= 3) begin : g_st3
    dsm_accum_stage #(.WIDTH(WIDTH)) u_st3 (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en),
      .clr_i  (clr3),
      .add_i  (s2),
      .cin_i  (1'b0),
      .sum_o  (s3),
      .cout_o (c3)
    );
  end else begin : g_no3
    assign s3 = '0;
    assign c3 = 1'b0;
  end

  logic unused_s;
  assign unused_s = ^{s2, s3};

  // Delays of a disabled stage read as zero on the step that drops it
  assign c2d1e = clr2 ? 1'b0 : c2d1_q;
  assign c3d1e = clr3 ? 1'b0 : c3d1_q;
  assign c3d2e = clr3 ? 1'b0 : c3d2_q;

  assign y = ext(c1)
           + ext(c2) - ext(c2d1e)
           + ext(c3)
           - {ext(c3d1e)[DSM_OUT_W-2:0], 1'b0}
           + ext(c3d2e);

  assign fb = lfsr_q[LFSR_W-LFSR_TAP_A]
            ^ lfsr_q[LFSR_W-LFSR_TAP_B];

  always_comb begin
    accept = din_valid & ~full_q;
    sh_d   = sh_q;
    full_d = full_q;
    x_d    = x_q;
    lfsr_d = lfsr_q;
    c2d1_d = c2d1_q;
    c3d1_d = c3d1_q;
    c3d2_d = c3d2_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    cy1_d  = cy1_q;
    if (accept) begin
      sh_d   = din;
      full_d = 1'b1;
    end
    if (en) begin
      if (full_q) begin
        x_d    = sh_q;
        full_d = 1'b0;
      end
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
      c2d1_d = c2;
      c3d1_d = c3;
      c3d2_d = clr3 ? 1'b0 : c3d1_q;
      dout_d = y;
      dv_d   = 1'b1;
      cy1_d  = c1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      sh_q   <= '0;
      full_q <= 1'b0;
      lfsr_q <= LFSR_W'(LFSR_SD);
      c2d1_q <= 1'b0;
      c3d1_q <= 1'b0;
      c3d2_q <= 1'b0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      cy1_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      sh_q   <= sh_d;
      full_q <= full_d;
      lfsr_q <= lfsr_d;
      c2d1_q <= c2d1_d;
      c3d1_q <= c3d1_d;
      c3d2_q <= c3d2_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      cy1_q  <= cy1_d;
    end
  end

  assign din_ready  = ~full_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign carry1     = cy1_q;

endmodule

// File: tb/tb_dsm_mash_mod.sv
// Directed self-checking bench for dsm_mash_mod
// (WIDTH=16, ORDER=3).
module tb_dsm_mash_mod;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   ord = 2'd1;
  logic         dither_en = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [3:0]   dout;
  logic         dout_valid;
  logic         carry1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsm_mash_mod #(
    .WIDTH   (W),
    .ORDER   (3),
    .LFSR_W  (15),
    .LFSR_SD (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ord        (ord),
    .dither_en  (dither_en),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .carry1     (carry1)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic int sd();
    return int'($signed(dout));
  endfunction

  task automatic cyc(input logic e, input logic v,
                     input logic [W-1:0] w);
    @(negedge clk);
    en = e;
    din_valid = v;
    din = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    din_valid = 1'b0;
    reset = 1'b0;
    #2;
    chk("rst_dout", sd(), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_ready", int'(din_ready), 1);
    chk("rst_carry1", int'(carry1), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Load a word with en=0, then run the step that moves it to x.
  task automatic load(input logic [W-1:0] w);
    cyc(1'b0, 1'b1, w);
    chk("load_ready_low", int'(din_ready), 0);
    cyc(1'b1, 1'b0, '0);
    chk("load_step_dout", sd(), 0);
    chk("load_ready_high", int'(din_ready), 1);
  endtask

  int exp2 [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
  int exp3 [8] = '{0, 1, -1, 2, -2, 3, -2, 1};
  int exp4 [5] = '{0, 0, 1, 0, 1};
  int sum;
  int nz;
  logic [14:0] lm;
  logic [16:0] am;
  logic [15:0] xm;

  initial begin
    do_reset();

    // Order 1, half scale: 0,1,0,1...
    ord = 2'd1;
    load(16'h8000);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("o1_half_dout", sd(), i % 2);
      chk("o1_half_valid", int'(dout_valid), 1);
      chk("o1_half_carry1", int'(carry1), i % 2);
    end
    cyc(1'b0, 1'b0, '0);
    chk("idle_valid", int'(dout_valid), 0);
    chk("idle_dout_hold", sd(), 1);

    // Order 1, full scale
    do_reset();
    load(16'hFFFF);
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (i == 0) chk("o1_full_first", sd(), 0);
      sum += sd();
    end
    chk("o1_full_sum32", sum, 31);

    // Order 3, zero input
    do_reset();
    ord = 2'd3;
    load(16'h0000);
    nz = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (dout != 4'd0) nz++;
    end
    chk("o3_zero_nonzero", nz, 0);

    // Order 2, quarter scale
    do_reset();
    ord = 2'd2;
    load(16'h4000);
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("o2_q_dout", sd(), exp2[i % 8]);
      sum += sd();
    end
    chk("o2_q_sum64", sum, 16);

    // Order 3, quarter scale
    do_reset();
    ord = 2'd3;
    load(16'h4000);
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("o3_q_dout", sd(), exp3[i % 8]);
      sum += sd();
    end
    chk("o3_q_sum64", sum, 16);

    // ord=0 falls back to order 1; acc1 is at 0 here
    ord = 2'd0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("ord0_dout", sd(), (i % 4 == 3) ? 1 : 0);
    end

    // Handshake: back-to-back offers with en=0
    do_reset();
    ord = 2'd1;
    cyc(1'b0, 1'b1, 16'h4000);
    chk("hs_first_acc", int'(din_ready), 0);
    chk("hs_idle_valid", int'(dout_valid), 0);
    cyc(1'b0, 1'b1, 16'h8000);
    chk("hs_second_held", int'(din_ready), 0);
    cyc(1'b1, 1'b1, 16'h8000);
    chk("hs_drained", int'(din_ready), 1);
    chk("hs_step_dout", sd(), 0);
    cyc(1'b0, 1'b1, 16'h8000);
    chk("hs_second_acc", int'(din_ready), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("hs_seq_dout", sd(), exp4[i]);
    end

    // Mid-stream asynchronous reset with order 3
    do_reset();
    ord = 2'd3;
    load(16'h4000);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0);
    chk("mid_pre_dout", sd(), -2);
    cyc(1'b0, 1'b1, 16'h1234);
    chk("mid_pre_full", int'(din_ready), 0);
    @(negedge clk);
    en = 1'b1;
    din_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_dout", sd(), 0);
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_ready", int'(din_ready), 1);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    load(16'h4000);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("mid_restart_dout", sd(), exp3[i]);
    end

    // Dither, order 1, checked against a stage-1 model
    do_reset();
    ord = 2'd1;
    dither_en = 1'b1;
    cyc(1'b0, 1'b1, 16'hC000);
    lm = 15'd1;
    am = '0;
    xm = '0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 1'b0, '0);
      am = {1'b0, am[15:0]} + {1'b0, xm}
         + {16'd0, lm[0]};
      lm = {lm[13:0], lm[14] ^ lm[13]};
      xm = 16'hC000;
      chk("dith_dout", sd(), int'(am[16]));
      chk("dith_carry1", int'(carry1), int'(am[16]));
    end

    // Dither alone on zero input stays at zero
    do_reset();
    load(16'h0000);
    nz = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (dout != 4'd0) nz++;
    end
    chk("dith_zero_nonzero", nz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
